// File: rtl/encrypt_shift_ctrl_pkg.sv
// Shared types, ASCII bounds and letter-code helpers for the encryption shift sequencer.
package encrypt_ctrl_pkg;

  localparam int unsigned KEY_DEPTH = 8;
  localparam int unsigned CREDITS   = 4;

  localparam logic [7:0] ASCII_UPPER_LO = 8'd65;
  localparam logic [7:0] ASCII_UPPER_HI = 8'd90;
  localparam logic [7:0] ASCII_LOWER_LO = 8'd97;
  localparam logic [7:0] ASCII_LOWER_HI = 8'd122;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_UPPER_LO) && (c <= ASCII_UPPER_HI);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= ASCII_LOWER_LO) && (c <= ASCII_LOWER_HI);
  endfunction

  // One-hot letter position for alphabetic bytes; the raw byte otherwise.
  function automatic logic [25:0] letter_code(input logic [7:0] c);
    if (is_upper(c)) begin
      return 26'd1 << (c - ASCII_UPPER_LO);
    end else if (is_lower(c)) begin
      return 26'd1 << (c - ASCII_LOWER_LO);
    end else begin
      return {18'b0, c};
    end
  endfunction

endpackage

// File: rtl/encrypt_shift_ctrl_if.sv
// Byte stream in, credit return, and registered pipe-beat outputs of the shift sequencer.
interface encrypt_shift_ctrl_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        credit_ret;
  logic        en;
  logic        mode;
  logic        shift_en;
  logic [2:0]  shift_amt;
  logic [25:0] extended_shift_in;
  logic        is_alpha_upper_case;
  logic        is_alpha_low_case;

  modport slave (
    input  in_valid, in_data, credit_ret,
    output in_ready, en, mode, shift_en, shift_amt, extended_shift_in,
           is_alpha_upper_case, is_alpha_low_case
  );

  modport master (
    output in_valid, in_data, credit_ret,
    input  in_ready, en, mode, shift_en, shift_amt, extended_shift_in,
           is_alpha_upper_case, is_alpha_low_case
  );
endinterface

// File: rtl/encrypt_shift_ctrl_key_regfile.sv
// 8x3 rotating-key storage: synchronous write port, asynchronous read.
module encrypt_key_regfile
  import encrypt_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [2:0] wdata,
  input  logic [2:0] raddr,
  output logic [2:0] rdata
);

  logic [2:0] mem [KEY_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < KEY_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/encrypt_shift_ctrl.sv
// Encryption shift-stage sequencer: classifies bytes, draws rotating key shifts, credit-gates beats.
// Build option: define ENCRYPT_SHIFT_CTRL_ALPHA_ADV_EN to advance the key only on alphabetic bytes.
module encrypt_shift_ctrl
  import encrypt_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_key_we,
  input  logic [2:0]            cfg_key_addr,
  input  logic [2:0]            cfg_key_data,
  input  logic [3:0]            cfg_key_len,
  input  logic                  cfg_mode,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  cred_err,
  encrypt_shift_ctrl_if.slave   pipe
);

  localparam logic [2:0] CREDIT_FULL = 3'(CREDITS);
  localparam logic [3:0] LEN_MAX     = 4'(KEY_DEPTH);

  state_t      state, state_nxt;
  logic [2:0]  credit_cnt;
  logic [2:0]  key_idx;
  logic [2:0]  key_rd;
  logic [3:0]  key_len;
  logic [3:0]  len_eff;
  logic        ready;
  logic        accept;
  logic        start_go;
  logic        key_adv;
  logic        idx_wrap;
  logic        overflow;
  logic        cred_err_q;

  logic        en_q;
  logic        mode_q;
  logic        shift_en_q;
  logic [2:0]  shift_amt_q;
  logic [25:0] ext_q;
  logic        upper_q;
  logic        lower_q;

  encrypt_key_regfile u_keys (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_key_we && (state == IDLE)),
    .waddr (cfg_key_addr),
    .wdata (cfg_key_data),
    .raddr (key_idx),
    .rdata (key_rd)
  );

  assign ready    = (state == RUN) && (credit_cnt != '0);
  assign accept   = pipe.in_valid && ready;
  assign start_go = (state == IDLE) && start;
  assign overflow = pipe.credit_ret && !accept && (credit_cnt == CREDIT_FULL);
  assign idx_wrap = ({1'b0, key_idx} == (key_len - 4'd1));
  assign len_eff  = (cfg_key_len == '0) ? 4'd1 :
                    (cfg_key_len > LEN_MAX) ? LEN_MAX : cfg_key_len;

`ifdef ENCRYPT_SHIFT_CTRL_ALPHA_ADV_EN
  assign key_adv = accept && (is_upper(pipe.in_data) || is_lower(pipe.in_data));
`else
  assign key_adv = accept;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop) state_nxt = DRAIN;
      DRAIN:   if (credit_cnt == CREDIT_FULL) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A return at full count saturates; a clear from start yields to a same-cycle overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CREDIT_FULL;
      cred_err_q <= 1'b0;
    end else begin
      if (accept && !pipe.credit_ret) begin
        credit_cnt <= credit_cnt - 3'd1;
      end else if (pipe.credit_ret && !accept && !overflow) begin
        credit_cnt <= credit_cnt + 3'd1;
      end
      if (start_go) cred_err_q <= 1'b0;
      if (overflow) cred_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_idx <= '0;
      key_len <= 4'd1;
      mode_q  <= 1'b0;
    end else if (start_go) begin
      key_idx <= '0;
      key_len <= len_eff;
      mode_q  <= cfg_mode;
    end else if (key_adv) begin
      key_idx <= idx_wrap ? '0 : key_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q        <= 1'b0;
      shift_en_q  <= 1'b0;
      shift_amt_q <= '0;
      ext_q       <= '0;
      upper_q     <= 1'b0;
      lower_q     <= 1'b0;
    end else begin
      en_q <= accept;
      if (accept) begin
        upper_q     <= is_upper(pipe.in_data);
        lower_q     <= is_lower(pipe.in_data);
        shift_en_q  <= is_upper(pipe.in_data) || is_lower(pipe.in_data);
        shift_amt_q <= key_rd;
        ext_q       <= letter_code(pipe.in_data);
      end
    end
  end

  assign pipe.in_ready            = ready;
  assign pipe.en                  = en_q;
  assign pipe.mode                = mode_q;
  assign pipe.shift_en            = shift_en_q;
  assign pipe.shift_amt           = shift_amt_q;
  assign pipe.extended_shift_in   = ext_q;
  assign pipe.is_alpha_upper_case = upper_q;
  assign pipe.is_alpha_low_case   = lower_q;
  assign busy                     = (state != IDLE);
  assign cred_err                 = cred_err_q;

endmodule

// File: tb/tb_encrypt_shift_ctrl.sv
// Randomized bench for encrypt_shift_ctrl against a transaction-level reference model.
module tb_encrypt_shift_ctrl;

  localparam int CRED_FULL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_key_we;
  logic [2:0] cfg_key_addr;
  logic [2:0] cfg_key_data;
  logic [3:0] cfg_key_len;
  logic       cfg_mode;
  logic       start;
  logic       stop;
  logic       busy;
  logic       cred_err;

  encrypt_shift_ctrl_if bus ();

  encrypt_shift_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_key_we   (cfg_key_we),
    .cfg_key_addr (cfg_key_addr),
    .cfg_key_data (cfg_key_data),
    .cfg_key_len  (cfg_key_len),
    .cfg_mode     (cfg_mode),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .cred_err     (cred_err),
    .pipe         (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0=idle 1=run 2=drain, plus last issued beat.
  int        m_phase, m_cred, m_idx, m_len;
  bit        m_err, m_mode;
  bit [2:0]  m_key [8];
  bit        m_en, m_se, m_up, m_lo;
  bit [2:0]  m_amt;
  bit [25:0] m_ext;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic reset_model();
    m_phase = 0; m_cred = CRED_FULL; m_idx = 0; m_len = 1;
    m_err = 0; m_mode = 0;
    m_en = 0; m_se = 0; m_up = 0; m_lo = 0; m_amt = 0; m_ext = 0;
    for (int i = 0; i < 8; i++) m_key[i] = 0;
  endtask

  task automatic check_outputs();
    check("en",        bus.en, m_en);
    check("mode",      bus.mode, m_mode);
    check("shift_en",  bus.shift_en, m_se);
    check("shift_amt", bus.shift_amt, m_amt);
    check("ext",       bus.extended_shift_in, m_ext);
    check("upper",     bus.is_alpha_upper_case, m_up);
    check("lower",     bus.is_alpha_low_case, m_lo);
    check("busy",      busy, (m_phase != 0));
    check("cred_err",  cred_err, m_err);
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic cycle(input bit v, input bit [7:0] d, input bit cr, input bit st, input bit sp);
    bit acc, up, lo, was_full;
    int kl;
    bus.in_valid = v; bus.in_data = d; bus.credit_ret = cr;
    start = st; stop = sp;
    #2;
    check("in_ready", bus.in_ready, (m_phase == 1 && m_cred > 0));
    acc      = v && (m_phase == 1) && (m_cred > 0);
    was_full = (m_cred == CRED_FULL);
    up = (d >= 65) && (d <= 90);
    lo = (d >= 97) && (d <= 122);
    if (acc) begin
      m_en = 1; m_up = up; m_lo = lo; m_se = up | lo;
      m_amt = m_key[m_idx];
      if (up)      m_ext = 26'd1 << (d - 8'd65);
      else if (lo) m_ext = 26'd1 << (d - 8'd97);
      else         m_ext = {18'd0, d};
`ifdef ENCRYPT_SHIFT_CTRL_ALPHA_ADV_EN
      if (up || lo)
`endif
        m_idx = (m_idx + 1) % m_len;
    end else begin
      m_en = 0;
    end
    if (cfg_key_we && m_phase == 0) m_key[cfg_key_addr] = cfg_key_data;
    if (m_phase == 0 && st) begin
      kl = int'(cfg_key_len);
      m_len = (kl == 0) ? 1 : ((kl > 8) ? 8 : kl);
      m_idx = 0; m_mode = cfg_mode; m_err = 0;
    end
    if (acc && !cr) m_cred--;
    else if (cr && !acc) begin
      if (was_full) m_err = 1;
      else m_cred++;
    end
    case (m_phase)
      0: if (st) m_phase = 1;
      1: if (sp) m_phase = 2;
      default: if (was_full) m_phase = 0;
    endcase
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_key(input bit [2:0] a, input bit [2:0] dt);
    cfg_key_we = 1; cfg_key_addr = a; cfg_key_data = dt;
    idle_cycle();
    cfg_key_we = 0;
  endtask

  task automatic stop_and_drain();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 50 && m_phase != 0; k++)
      cycle(1'b0, 8'h00, (m_cred < CRED_FULL), 1'b0, 1'b0);
    check("drain_done", busy, 1'b0);
  endtask

  function automatic bit [7:0] pick_byte();
    case ($urandom_range(0, 2))
      0:       return 8'(65 + $urandom_range(0, 25));
      1:       return 8'(97 + $urandom_range(0, 25));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int cnt;
    rst = 1; cfg_key_we = 0; cfg_key_addr = 0; cfg_key_data = 0;
    cfg_key_len = 0; cfg_mode = 0; start = 0; stop = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.credit_ret = 0;
    reset_model();
    #3;
    check_outputs();
    check("rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 0;

    // Keys {1,2,3}, length 3, mode 1, bytes "aB!"
    write_key(0, 1); write_key(1, 2); write_key(2, 3);
    cfg_key_len = 3; cfg_mode = 1;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    check("ex_b1_ext", bus.extended_shift_in, 26'h1);
    check("ex_b1_amt", bus.shift_amt, 3'd1);
    cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    check("ex_b2_ext", bus.extended_shift_in, 26'h2);
    check("ex_b2_amt", bus.shift_amt, 3'd2);
    cycle(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    check("ex_b3_ext", bus.extended_shift_in, 26'h21);
    check("ex_b3_amt", bus.shift_amt, 3'd3);
    check("ex_b3_sen", bus.shift_en, 1'b0);
    stop_and_drain();

    // Credit exhaustion with in_valid held, then a single return.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
      cnt += int'(bus.en);
    end
    check("exhaust_accepts", cnt, 4);
    cycle(1'b1, 8'h79, 1'b1, 1'b0, 1'b0);
    cnt = int'(bus.en);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'h79, 1'b0, 1'b0, 1'b0);
      cnt += int'(bus.en);
    end
    check("one_more_accept", cnt, 1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Stop with two credits outstanding.
    cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("stop_busy_1", busy, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("stop_busy_2", busy, 1'b1);
    idle_cycle();
    check("stop_idle", busy, 1'b0);

    // Credit return at full count, then start clears the flag.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("cred_err_set", cred_err, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("cred_err_clr", cred_err, 1'b0);
    stop_and_drain();

    // Length 0 acts as 1; key write while busy is dropped.
    write_key(0, 5); write_key(1, 6);
    cfg_key_len = 0; cfg_mode = 0;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h63, 1'b0, 1'b0, 1'b0);
    check("len0_amt1", bus.shift_amt, 3'd5);
    cfg_key_we = 1; cfg_key_addr = 0; cfg_key_data = 7;
    cycle(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
    cfg_key_we = 0;
    cycle(1'b1, 8'h65, 1'b1, 1'b0, 1'b0);
    check("busy_write_drop", bus.shift_amt, 3'd5);
    stop_and_drain();

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 8; a++) write_key(3'(a), 3'($urandom_range(0, 7)));
      cfg_key_len = 4'($urandom_range(0, 15));
      cfg_mode = 1'($urandom_range(0, 1));
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 40; k++)
        cycle(($urandom_range(0, 3) != 0), pick_byte(),
              (m_cred < CRED_FULL) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 15) == 0), 1'b0);
      stop_and_drain();
    end

    // Asynchronous reset in the middle of a run.
    cfg_key_len = 2; cfg_mode = 1;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h5a, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h7a, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1;
    #1;
    reset_model();
    check_outputs();
    check("midrst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    bus.in_valid = 0;
    cfg_key_len = 1;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
    check("post_rst_key", bus.shift_amt, 3'd0);
    stop_and_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
